rr_arbiter_n: RTL

Parametrised N-requester bus arbiter with transaction-based grant holding. It supports round-robin or fixed-priority selection, an optional maximum-hold timeout that revokes a stuck grant, and an encoded grant index. It sits between N bus masters and a shared target. Each master holds `req` until granted and pulses `end_txn` to release the grant.

---
 rtl/rr_arbiter_n.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_n.sv
// N-requester bus arbiter: round-robin or fixed-priority selection, grant held
// until end_txn from the owner or an optional max-hold timeout revokes it.
module rr_arbiter_n #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      end_txn,
    input  logic                    prio_mode,
    output logic [NUM_REQ-1:0]      grant,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = 16;
    localparam logic            TO_EN     = (MAX_HOLD > 0) ? 1'b1 : 1'b0;
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [NUM_REQ-1:0]     grant_r, grant_s;
    logic [IDW-1:0]         grant_id_r, grant_id_s;
    logic                   busy_r, busy_s;
    logic                   timeout_r, timeout_s;
    logic [IDW-1:0]         last_r, last_s;
    logic [CNTW-1:0]        cnt_r, cnt_s;
    logic [IDW-1:0]         win_s;

    // Winner index; the scan order makes the lowest index / nearest-after-last win.
    function automatic logic [IDW-1:0] pick_winner(
        input logic [NUM_REQ-1:0] r,
        input logic [IDW-1:0]     last,
        input logic               fixed
    );
        logic [IDW-1:0] idx;
        int             j;
        idx = '0;
        if (fixed) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (r[i]) begin
                    idx = IDW'(i);
                end else begin
                    idx = idx;
                end
            end
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                j = (int'(last) + k) % NUM_REQ;
                if (r[j]) begin
                    idx = IDW'(j);
                end else begin
                    idx = idx;
                end
            end
        end
        return idx;
    endfunction

    // Arbitration winner for the current request vector.
    always_comb begin
        win_s = pick_winner(req, last_r, prio_mode);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        grant_id_s = grant_id_r;
        busy_s     = busy_r;
        timeout_s  = 1'b0;
        last_s     = last_r;
        cnt_s      = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s    = ST_GNT;
                    grant_s    = NUM_REQ'(1'b1) << win_s;
                    grant_id_s = win_s;
                    busy_s     = 1'b1;
                    cnt_s      = '0;
                end else begin
                    grant_s    = '0;
                    grant_id_s = '0;
                    busy_s     = 1'b0;
                end
            end
            ST_GNT: begin
                // A same-cycle end_txn wins over the timeout, so no pulse then.
                if (end_txn[grant_id_r]) begin
                    state_s    = ST_IDLE;
                    grant_s    = '0;
                    grant_id_s = '0;
                    busy_s     = 1'b0;
                    last_s     = grant_id_r;
                end else if (TO_EN && (cnt_r == HOLD_LAST)) begin
                    state_s    = ST_IDLE;
                    grant_s    = '0;
                    grant_id_s = '0;
                    busy_s     = 1'b0;
                    last_s     = grant_id_r;
                    timeout_s  = 1'b1;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_s = cnt_r + CNTW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                grant_s    = '0;
                grant_id_s = '0;
                busy_s     = 1'b0;
                cnt_s      = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            grant_id_r <= '0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
            last_r     <= IDW'(NUM_REQ - 1);
            cnt_r      <= '0;
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            grant_id_r <= grant_id_s;
            busy_r     <= busy_s;
            timeout_r  <= timeout_s;
            last_r     <= last_s;
            cnt_r      <= cnt_s;
        end
    end

    assign grant    = grant_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;
    assign timeout  = timeout_r;

endmodule
